mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Sequences CPU memory traffic onto one shared, variable-latency memory port.
//  - Sits between mips_cpu_harvard's separate instr/data ports and a single unified memory.
//  - Serves each CPU step as: data access first, then instruction fetch.
//  - Stalls the CPU through clk_enable until both accesses complete, and counts stall cycles.
// PARAMETERS
//  STALL_CNT_W  16  width of the saturating stall-cycle counter
// PORTS
//  clk              in   1   system clock; all state changes on posedge
//  reset            in   1   synchronous, active-high
//  clk_enable       out  1   one-cycle pulse: the CPU may advance one step
//  instr_req        in   1   CPU wants an instruction fetch this step
//  instr_address    in   32  fetch address
//  instr_readdata   out  32  fetched word; held until the next fetch capture
//  data_read        in   1   CPU load request
//  data_write       in   1   CPU store request
//  data_address     in   32  load/store address
//  data_writedata   in   32  store data
//  data_byteenable  in   4   store byte lanes
//  data_readdata    out  32  loaded word; held until the next load capture
//  mem_address      out  32  shared-port address
//  mem_read         out  1   shared-port read strobe
//  mem_write        out  1   shared-port write strobe
//  mem_writedata    out  32  shared-port write data
//  mem_byteenable   out  4   shared-port byte lanes (4'hF on reads)
//  mem_waitrequest  in   1   high = memory has not accepted/completed the current access
//  mem_readdata     in   32  read data; valid in the cycle mem_waitrequest is low
//  stall_cycles     out  STALL_CNT_W  cycles with clk_enable low since reset; saturates at all-ones
//  protocol_err     out  1   sticky; set when data_read and data_write are sampled high together
// BEHAVIOUR
//  - FSM states: IDLE, DATA, FETCH, DONE.
//  - Reset (sync) forces:
//    - state=IDLE; clk_enable=0; mem_read=mem_write=0; mem_address=0; mem_byteenable=0.
//    - instr_readdata=0; data_readdata=0; stall_cycles=0; protocol_err=0.
//  - Reset asserted mid-access aborts the access: strobes are low in the cycle after the reset
//    edge and nothing is captured.
//  - IDLE:
//    - Sample all CPU request inputs into internal registers.
//    - Next state: DATA if (data_read|data_write); else FETCH if instr_req; else stay IDLE.
//  - Read+write both high: set protocol_err; perform the write only.
//  - DATA: drive mem_* from the latched data request.
//    - Hold mem_* stable while mem_waitrequest=1.
//    - When mem_waitrequest=0: a read captures mem_readdata into data_readdata.
//    - Next state: FETCH if instr_req was latched, else DONE.
//  - FETCH: mem_read=1, mem_address=latched instr_address, mem_byteenable=4'hF.
//    - When mem_waitrequest=0: capture mem_readdata into instr_readdata; next state DONE.
//  - DONE: clk_enable=1 for exactly this cycle, strobes low; next state IDLE.
//  - mem_* outputs are driven only from state and latched registers.
//    - No combinational path from CPU inputs to mem_*.
//    - CPU input changes after sampling have no effect on the current step.
//  - mem_read and mem_write are never high in the same cycle.
//  - Zero-wait latency, counted from the IDLE sampling edge to the clk_enable-high cycle:
//    - fetch only: 2 cycles;
//    - data+fetch: 3 cycles;
//    - each mem_waitrequest-high cycle adds 1.
//  - stall_cycles increments on every non-reset cycle with clk_enable=0; it holds at 2^STALL_CNT_W-1.
// TESTING
//  1. Reset: hold reset 2 cycles -> all outputs at reset values; mem_read=mem_write=0 throughout.
//  2. Fetch only, no wait:
//     - Stimulus: instr_req=1, instr_address=32'hBFC00000; memory returns 32'h24010020.
//     - Required: mem_read at 0xBFC00000 for 1 cycle, then clk_enable pulse 2 cycles after
//       sampling, instr_readdata=32'h24010020.
//  3. Load + fetch:
//     - Stimulus: data_read=1, data_address=32'h00000014, mem returns 32'hF0000000;
//       instr_address=32'hBFC00004.
//     - Required: mem_address sequence 0x14 then 0xBFC00004; data_readdata=32'hF0000000;
//       clk_enable pulse 3 cycles after sampling.
//  4. Wait states:
//     - Stimulus: mem_waitrequest high 3 cycles during the DATA store (data_write=1,
//       data_writedata=32'hDEADBEEF, byteenable=4'b0011).
//     - Required: mem_* stable for all 4 DATA cycles; clk_enable at cycle 6; stall_cycles
//       advanced by 6.
//  5. Protocol error: data_read=data_write=1 -> only mem_write issued; protocol_err=1 and
//     stays set until reset.
//  6. Reset mid-FETCH with mem_waitrequest=1:
//     - Required: mem_read=0 in the cycle after the reset edge; instr_readdata unchanged (0);
//       FSM back in IDLE.
//     - Also: with STALL_CNT_W=4, 20 stalled cycles -> stall_cycles=4'hF.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Serialises the Harvard CPU's data and instruction requests onto one shared,
// variable-latency memory port, gating CPU progress through clk_enable.
module mips_mem_arbiter #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   clk_enable,
  input  logic                   instr_req,
  input  logic [31:0]            instr_address,
  output logic [31:0]            instr_readdata,
  input  logic                   data_read,
  input  logic                   data_write,
  input  logic [31:0]            data_address,
  input  logic [31:0]            data_writedata,
  input  logic [3:0]             data_byteenable,
  output logic [31:0]            data_readdata,
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [31:0]            mem_writedata,
  output logic [3:0]             mem_byteenable,
  input  logic                   mem_waitrequest,
  input  logic [31:0]            mem_readdata,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   protocol_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  localparam logic [BW-1:0]          BE_ALL    = '1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Request snapshot taken in IDLE; the step runs from this copy only
  logic          r_ireq;
  logic [AW-1:0] r_iaddr;
  logic          r_dread;
  logic          r_dwrite;
  logic [AW-1:0] r_daddr;
  logic [DW-1:0] r_dwdata;
  logic [BW-1:0] r_dbe;

  logic                   r_clk_enable;
  logic [AW-1:0]          r_mem_address;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [DW-1:0]          r_mem_writedata;
  logic [BW-1:0]          r_mem_byteenable;
  logic [DW-1:0]          r_instr_readdata;
  logic [DW-1:0]          r_data_readdata;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   r_protocol_err;

  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_dread;
  logic          w_dwrite;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_dwdata;
  logic [BW-1:0] w_dbe;
  logic          w_accept;

  logic          w_clk_enable_nx;
  logic [AW-1:0] w_mem_address_nx;
  logic          w_mem_read_nx;
  logic          w_mem_write_nx;
  logic [DW-1:0] w_mem_writedata_nx;
  logic [BW-1:0] w_mem_byteenable_nx;

  assign w_accept = ~mem_waitrequest;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and next registered port values
  always_comb begin
    w_state_nx          = r_state;
    w_clk_enable_nx     = 1'b0;
    w_mem_read_nx       = 1'b0;
    w_mem_write_nx      = 1'b0;
    w_mem_address_nx    = r_mem_address;
    w_mem_writedata_nx  = r_mem_writedata;
    w_mem_byteenable_nx = r_mem_byteenable;

    w_ireq   = r_ireq;
    w_iaddr  = r_iaddr;
    w_dread  = r_dread;
    w_dwrite = r_dwrite;
    w_daddr  = r_daddr;
    w_dwdata = r_dwdata;
    w_dbe    = r_dbe;
    if (r_state == IDLE) begin
      w_ireq   = instr_req;
      w_iaddr  = instr_address;
      w_dread  = data_read;
      w_dwrite = data_write;
      w_daddr  = data_address;
      w_dwdata = data_writedata;
      w_dbe    = data_byteenable;
    end

    case (r_state)
      IDLE: begin
        if (w_dread | w_dwrite) begin
          w_state_nx = DATA;
        end else if (w_ireq) begin
          w_state_nx = FETCH;
        end
      end
      DATA: begin
        if (w_accept) begin
          w_state_nx = w_ireq ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (w_accept) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase

    // A simultaneous read+write request is issued as the write alone
    case (w_state_nx)
      DATA: begin
        w_mem_read_nx       = w_dread & ~w_dwrite;
        w_mem_write_nx      = w_dwrite;
        w_mem_address_nx    = w_daddr;
        w_mem_writedata_nx  = w_dwdata;
        w_mem_byteenable_nx = w_dwrite ? w_dbe : BE_ALL;
      end
      FETCH: begin
        w_mem_read_nx       = 1'b1;
        w_mem_address_nx    = w_iaddr;
        w_mem_byteenable_nx = BE_ALL;
      end
      DONE: begin
        w_clk_enable_nx = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Request snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ireq   <= 1'b0;
      r_iaddr  <= '0;
      r_dread  <= 1'b0;
      r_dwrite <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dbe    <= '0;
    end else if (r_state == IDLE) begin
      r_ireq   <= instr_req;
      r_iaddr  <= instr_address;
      r_dread  <= data_read;
      r_dwrite <= data_write;
      r_daddr  <= data_address;
      r_dwdata <= data_writedata;
      r_dbe    <= data_byteenable;
    end
  end

  // Registered memory port, CPU handshake and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_enable     <= 1'b0;
      r_mem_address    <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_writedata  <= '0;
      r_mem_byteenable <= '0;
      r_instr_readdata <= '0;
      r_data_readdata  <= '0;
    end else begin
      r_clk_enable     <= w_clk_enable_nx;
      r_mem_address    <= w_mem_address_nx;
      r_mem_read       <= w_mem_read_nx;
      r_mem_write      <= w_mem_write_nx;
      r_mem_writedata  <= w_mem_writedata_nx;
      r_mem_byteenable <= w_mem_byteenable_nx;
      if ((r_state == DATA) && w_accept && r_dread && !r_dwrite) begin
        r_data_readdata <= mem_readdata;
      end
      if ((r_state == FETCH) && w_accept) begin
        r_instr_readdata <= mem_readdata;
      end
    end
  end

  // Sticky protocol error and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_protocol_err <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if ((r_state == IDLE) && data_read && data_write) begin
        r_protocol_err <= 1'b1;
      end
      if (!r_clk_enable && (r_stall_cycles != STALL_MAX)) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

  assign clk_enable     = r_clk_enable;
  assign mem_address    = r_mem_address;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_writedata  = r_mem_writedata;
  assign mem_byteenable = r_mem_byteenable;
  assign instr_readdata = r_instr_readdata;
  assign data_readdata  = r_data_readdata;
  assign stall_cycles   = r_stall_cycles;
  assign protocol_err   = r_protocol_err;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a table of CPU steps with a scripted
// memory responder, plus reset-abort and stall-counter saturation sequences.
module tb_mips_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [15:0] stall_cycles;
  logic        protocol_err;

  // Small-counter instance, kept idle
  logic        reset2;
  logic        ce2;
  logic [31:0] ird2;
  logic [31:0] drd2;
  logic [31:0] maddr2;
  logic        mrd2;
  logic        mwr2;
  logic [31:0] mwd2;
  logic [3:0]  mbe2;
  logic [3:0]  stall2;
  logic        perr2;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

  mips_mem_arbiter #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .instr_req(instr_req), .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .stall_cycles(stall_cycles), .protocol_err(protocol_err)
  );

  mips_mem_arbiter #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .reset(reset2), .clk_enable(ce2),
    .instr_req(1'b0), .instr_address(32'h0), .instr_readdata(ird2),
    .data_read(1'b0), .data_write(1'b0), .data_address(32'h0),
    .data_writedata(32'h0), .data_byteenable(4'h0),
    .data_readdata(drd2), .mem_address(maddr2), .mem_read(mrd2),
    .mem_write(mwr2), .mem_writedata(mwd2), .mem_byteenable(mbe2),
    .mem_waitrequest(1'b0), .mem_readdata(32'h0),
    .stall_cycles(stall2), .protocol_err(perr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ireq;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] memd;
    int          wd;
    logic [31:0] iaddr;
    logic [31:0] memi;
    int          wf;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
    logic        exp_perr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rd, input logic wr, input logic ireq,
                              input logic [31:0] daddr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] memd, input int wd,
                              input logic [31:0] iaddr, input logic [31:0] memi, input int wf,
                              input logic [31:0] exp_d, input logic [31:0] exp_i,
                              input logic exp_perr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ireq = ireq;
    v.daddr = daddr; v.wdata = wdata; v.be = be; v.memd = memd; v.wd = wd;
    v.iaddr = iaddr; v.memi = memi; v.wf = wf;
    v.exp_d = exp_d; v.exp_i = exp_i; v.exp_perr = exp_perr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One CPU step: present request, script memory waits, check every cycle
  task automatic run_step(input vec_t v, input int idx);
    int          nd;
    int          nf;
    logic        erd;
    logic        ewr;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        wt;
    logic [31:0] rdat;
    nd = (v.rd | v.wr) ? 1 + v.wd : 0;
    nf = v.ireq ? 1 + v.wf : 0;
    data_read = v.rd; data_write = v.wr; instr_req = v.ireq;
    data_address = v.daddr; data_writedata = v.wdata; data_byteenable = v.be;
    instr_address = v.iaddr; mem_waitrequest = 1'b0; mem_readdata = 32'h0;
    step();
    exp_stall++;
    // Scramble CPU inputs: the step must run from the sampled copy
    data_read = 1'b0; data_write = 1'b0; instr_req = 1'b0;
    data_address = 32'hFFFF_FFF0; instr_address = 32'hEEEE_EEE0;
    data_writedata = 32'h1357_9BDF; data_byteenable = 4'h0;
    for (int c = 0; c < nd + nf; c++) begin
      if (c < nd) begin
        erd = v.rd & ~v.wr; ewr = v.wr; eaddr = v.daddr;
        ebe = v.wr ? v.be : 4'hF; wt = (c < v.wd); rdat = v.memd;
      end else begin
        erd = 1'b1; ewr = 1'b0; eaddr = v.iaddr;
        ebe = 4'hF; wt = ((c - nd) < v.wf); rdat = v.memi;
      end
      chk($sformatf("v%0d_c%0d_rd", idx, c), 32'(mem_read), 32'(erd));
      chk($sformatf("v%0d_c%0d_wr", idx, c), 32'(mem_write), 32'(ewr));
      chk($sformatf("v%0d_c%0d_addr", idx, c), mem_address, eaddr);
      chk($sformatf("v%0d_c%0d_be", idx, c), 32'(mem_byteenable), 32'(ebe));
      chk($sformatf("v%0d_c%0d_ce", idx, c), 32'(clk_enable), 32'd0);
      if (ewr) chk($sformatf("v%0d_c%0d_wdata", idx, c), mem_writedata, v.wdata);
      mem_waitrequest = wt;
      mem_readdata = wt ? 32'h0BAD_0BAD : rdat;
      step();
      exp_stall++;
    end
    mem_waitrequest = 1'b0;
    mem_readdata = 32'h0;
    chk($sformatf("v%0d_done_ce", idx), 32'(clk_enable), 32'd1);
    chk($sformatf("v%0d_done_rd", idx), 32'(mem_read), 32'd0);
    chk($sformatf("v%0d_done_wr", idx), 32'(mem_write), 32'd0);
    chk($sformatf("v%0d_dread", idx), data_readdata, v.exp_d);
    chk($sformatf("v%0d_iread", idx), instr_readdata, v.exp_i);
    chk($sformatf("v%0d_perr", idx), 32'(protocol_err), 32'(v.exp_perr));
    chk($sformatf("v%0d_stall", idx), 32'(stall_cycles), 32'(exp_stall));
    step();
    chk($sformatf("v%0d_ce_pulse", idx), 32'(clk_enable), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                 32'hBFC0_0000, 32'h2401_0020, 0, 32'h0, 32'h2401_0020, 1'b0);
    vecs[1] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0014, 32'h0, 4'h0, 32'hF000_0000, 0,
                 32'hBFC0_0004, 32'h8C22_0000, 0, 32'hF000_0000, 32'h8C22_0000, 1'b0);
    vecs[2] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 4'b0011, 32'h0BAD_F00D, 3,
                 32'hBFC0_0008, 32'h3C01_1000, 0, 32'hF000_0000, 32'h3C01_1000, 1'b0);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 4'hF, 32'h5555_5555, 0,
                 32'h0, 32'h0, 0, 32'hF000_0000, 32'h3C01_1000, 1'b0);
    vecs[4] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hCAFE_F00D, 1,
                 32'h0, 32'h0, 0, 32'hCAFE_F00D, 32'h3C01_1000, 1'b0);
    vecs[5] = mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 0,
                 32'hBFC0_000C, 32'h0000_0001, 2, 32'hCAFE_F00D, 32'h0000_0001, 1'b0);
    vecs[6] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b1100, 32'h6666_6666, 0,
                 32'hBFC0_0010, 32'h1111_1111, 0, 32'hCAFE_F00D, 32'h1111_1111, 1'b1);
    vecs[7] = mk(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0, 4'h0, 32'h0000_0077, 0,
                 32'hBFC0_0014, 32'h0000_0022, 1, 32'h0000_0077, 32'h0000_0022, 1'b1);

    reset = 1'b1; reset2 = 1'b1;
    instr_req = 1'b0; instr_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; data_address = 32'h0;
    data_writedata = 32'h0; data_byteenable = 4'h0;
    mem_waitrequest = 1'b0; mem_readdata = 32'h0;

    // Two reset cycles
    step();
    chk("rst1_rd", 32'(mem_read), 32'd0);
    chk("rst1_wr", 32'(mem_write), 32'd0);
    step();
    chk("rst_ce", 32'(clk_enable), 32'd0);
    chk("rst_rd", 32'(mem_read), 32'd0);
    chk("rst_wr", 32'(mem_write), 32'd0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_be", 32'(mem_byteenable), 32'd0);
    chk("rst_iread", instr_readdata, 32'h0);
    chk("rst_dread", data_readdata, 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    exp_stall = 0;

    for (int i = 0; i < NV; i++) begin
      run_step(vecs[i], i);
    end

    // Reset during a waited fetch aborts it
    instr_req = 1'b1; instr_address = 32'hBFC0_0020;
    step();
    instr_req = 1'b0; instr_address = 32'h0;
    chk("rf_rd_start", 32'(mem_read), 32'd1);
    chk("rf_addr", mem_address, 32'hBFC0_0020);
    mem_waitrequest = 1'b1; mem_readdata = 32'h9999_9999;
    step();
    chk("rf_rd_held", 32'(mem_read), 32'd1);
    reset = 1'b1;
    step();
    chk("rf_rd_after_rst", 32'(mem_read), 32'd0);
    chk("rf_wr_after_rst", 32'(mem_write), 32'd0);
    chk("rf_iread", instr_readdata, 32'h0);
    chk("rf_dread", data_readdata, 32'h0);
    chk("rf_ce", 32'(clk_enable), 32'd0);
    chk("rf_stall", 32'(stall_cycles), 32'd0);
    chk("rf_perr", 32'(protocol_err), 32'd0);
    reset = 1'b0; mem_waitrequest = 1'b0; mem_readdata = 32'h0;
    exp_stall = 0;
    step();
    exp_stall++;
    chk("rf_idle_rd", 32'(mem_read), 32'd0);
    chk("rf_idle_ce", 32'(clk_enable), 32'd0);
    run_step(vecs[0], 100);

    // Narrow counter saturates at all-ones
    reset2 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", 32'(stall2), 32'd14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_20", 32'(stall2), 32'd15);
    chk("sat_ce", 32'(ce2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
